// File: rtl/pellet_tracker.sv
// -----------------------------------------------------------------------------
// pellet_tracker
//
// Tracks which 16x16 tiles of the 640x480 playfield still hold a pellet.
// After reset or restart it copies the pellet-map ROM into a register bitmap.
// Once per frame it looks up the tile under the player's centre point. If that
// tile holds a pellet, it clears the pellet, adds to the score and decrements
// the remaining-pellet count.
//
// Ports
//   Clk, Reset_n      : clock; synchronous active-low reset
//   frame_tick        : one-cycle pulse per frame, honoured only in IDLE
//   restart           : reload the pellet map; the score is kept
//   BallX, BallY      : top-left pixel of the 16x16 player sprite
//   rom_addr/rom_data : pellet-map ROM port; data arrives one cycle after address
//   DrawX, DrawY      : current VGA pixel
//   pellet_pix        : combinational "pellet dot at this pixel"
//   score             : saturating score
//   pellets_left      : pellets remaining in the map
//   eat_pulse         : one-cycle strobe when a pellet is eaten
//   level_clear       : ready and no pellets left
//   ready             : FSM is idle
// -----------------------------------------------------------------------------
module pellet_tracker #(
    parameter int TILE_COLS    = 40,
    parameter int TILE_ROWS    = 30,
    parameter int PELLET_VALUE = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        restart,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    output logic [10:0] rom_addr,
    input  logic        rom_data,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        pellet_pix,
    output logic [15:0] score,
    output logic [10:0] pellets_left,
    output logic        eat_pulse,
    output logic        level_clear,
    output logic        ready
);

    localparam int N = TILE_COLS * TILE_ROWS;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [10:0] LAST_K = 11'(N);

    logic [1:0]   state_r;
    logic [10:0]  k_r;
    logic [N-1:0] bitmap_r;
    logic [10:0]  idx_r;
    logic         hit_r;
    logic [15:0]  score_r;
    logic [10:0]  pellets_left_r;

    logic [10:0]  cx_s, cy_s;
    logic [6:0]   col_s, row_s;
    logic         valid_s;
    logic [10:0]  lookup_idx_s;
    logic         hit_s;
    logic [10:0]  pix_idx_s;
    logic         pix_in_range_s;
    logic         pix_in_dot_s;

    // Adds one pellet's worth of points and clamps at the 16-bit maximum.
    function automatic logic [15:0] sat_add(input logic [15:0] s);
        logic [16:0] sum;
        sum = {1'b0, s} + 17'(PELLET_VALUE);
        if (sum > 17'd65535) begin
            sat_add = 16'hFFFF;
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

    // Maps the player's centre point to a tile index and decides whether it holds a pellet.
    always_comb begin
        cx_s         = {1'b0, BallX} + 11'd8;
        cy_s         = {1'b0, BallY} + 11'd8;
        col_s        = cx_s[10:4];
        row_s        = cy_s[10:4];
        valid_s      = ({4'd0, col_s} < 11'(TILE_COLS)) && ({4'd0, row_s} < 11'(TILE_ROWS));
        lookup_idx_s = ({4'd0, row_s} * 11'(TILE_COLS)) + {4'd0, col_s};
        if (valid_s) begin
            hit_s = bitmap_r[lookup_idx_s];
        end else begin
            hit_s = 1'b0;
        end
    end

    // Generates the 4x4 pellet dot centred in each occupied tile (pixels 6..9 on both axes).
    always_comb begin
        pix_idx_s      = ({5'd0, DrawY[9:4]} * 11'(TILE_COLS)) + {5'd0, DrawX[9:4]};
        pix_in_range_s = ({5'd0, DrawX[9:4]} < 11'(TILE_COLS)) && ({5'd0, DrawY[9:4]} < 11'(TILE_ROWS));
        pix_in_dot_s   = (DrawX[3:0] >= 4'd6) && (DrawX[3:0] <= 4'd9) &&
                         (DrawY[3:0] >= 4'd6) && (DrawY[3:0] <= 4'd9);
        if (pix_in_range_s && pix_in_dot_s) begin
            pellet_pix = bitmap_r[pix_idx_s];
        end else begin
            pellet_pix = 1'b0;
        end
    end

    // Raises level_clear once the FSM is idle and the map is empty.
    always_comb begin
        if ((state_r == ST_IDLE) && (pellets_left_r == 11'd0)) begin
            level_clear = 1'b1;
        end else begin
            level_clear = 1'b0;
        end
    end

    // Main FSM: map load sweep, per-frame lookup and pellet consumption.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r        <= ST_INIT;
            k_r            <= 11'd0;
            bitmap_r       <= '0;
            idx_r          <= 11'd0;
            hit_r          <= 1'b0;
            score_r        <= 16'd0;
            pellets_left_r <= 11'd0;
        end else if (restart) begin
            state_r        <= ST_INIT;
            k_r            <= 11'd0;
            bitmap_r       <= '0;
            hit_r          <= 1'b0;
            pellets_left_r <= 11'd0;
        end else begin
            hit_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    // rom_data belongs to the address issued on the previous cycle (k-1).
                    if (k_r != 11'd0) begin
                        bitmap_r[k_r - 11'd1] <= rom_data;
                        if (rom_data) begin
                            pellets_left_r <= pellets_left_r + 11'd1;
                        end else begin
                            pellets_left_r <= pellets_left_r;
                        end
                    end else begin
                        pellets_left_r <= pellets_left_r;
                    end
                    if (k_r == LAST_K) begin
                        state_r <= ST_IDLE;
                    end else begin
                        k_r <= k_r + 11'd1;
                    end
                end
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_r <= ST_LOOKUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    // The hit is registered here so that eat_pulse comes straight from a flop in UPDATE.
                    idx_r   <= lookup_idx_s;
                    hit_r   <= hit_s;
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (hit_r) begin
                        bitmap_r[idx_r] <= 1'b0;
                        score_r         <= sat_add(score_r);
                        pellets_left_r  <= pellets_left_r - 11'd1;
                    end else begin
                        score_r <= score_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_INIT;
                    k_r     <= 11'd0;
                end
            endcase
        end
    end

    assign rom_addr     = k_r;
    assign score        = score_r;
    assign pellets_left = pellets_left_r;
    assign eat_pulse    = hit_r;
    assign ready        = (state_r == ST_IDLE);

endmodule

// File: tb/tb_pellet_tracker.sv
// -----------------------------------------------------------------------------
// tb_pellet_tracker
//
// Directed self-checking bench for pellet_tracker. A synchronous ROM model
// returns data one cycle after the address. One map holds pellets at 0, 41 and
// 1199, another is full and a third is empty. Each scenario task checks its own
// results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pellet_tracker;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  BallX = 10'd0;
    logic [9:0]  BallY = 10'd0;
    logic [10:0] rom_addr;
    logic        rom_data = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        pellet_pix;
    logic [15:0] score;
    logic [10:0] pellets_left;
    logic        eat_pulse;
    logic        level_clear;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    int rom_mode = 0;

    pellet_tracker #(.TILE_COLS(40), .TILE_ROWS(30), .PELLET_VALUE(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .restart(restart),
        .BallX(BallX), .BallY(BallY), .rom_addr(rom_addr), .rom_data(rom_data),
        .DrawX(DrawX), .DrawY(DrawY), .pellet_pix(pellet_pix), .score(score),
        .pellets_left(pellets_left), .eat_pulse(eat_pulse),
        .level_clear(level_clear), .ready(ready)
    );

    always #5 Clk = ~Clk;

    // Pellet maps: 0 = pellets at 0/41/1199, 1 = every tile, 2 = empty.
    function automatic logic rom_bit(input int mode, input logic [10:0] a);
        if (mode == 0) return (a == 11'd0) || (a == 11'd41) || (a == 11'd1199);
        else if (mode == 1) return (a < 11'd1200);
        else return 1'b0;
    endfunction

    // Synchronous ROM: data for an address appears after the next edge.
    always @(posedge Clk) rom_data <= rom_bit(rom_mode, rom_addr);

    // Advances n clock edges and leaves the time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Issues one frame tick at (bx,by) and reports whether eat_pulse fired in UPDATE.
    task automatic eat_one(input logic [9:0] bx, input logic [9:0] by, output logic pulsed);
        BallX = bx; BallY = by; frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        pulsed = eat_pulse;
        step(1);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; DrawX = 10'd6; DrawY = 10'd6;
        step(3);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score got=%0d exp=0", score); end
        n_checks++; if (pellets_left !== 11'd0) begin n_fail++; $display("FAIL reset_left got=%0d exp=0", pellets_left); end
        n_checks++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_eat got=%b exp=0", eat_pulse); end
        n_checks++; if (level_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear got=%b exp=0", level_clear); end
        n_checks++; if (pellet_pix !== 1'b0) begin n_fail++; $display("FAIL reset_pix got=%b exp=0", pellet_pix); end
        Reset_n = 1'b1;
        step(1);
        n_checks++; if (rom_addr !== 11'd1) begin n_fail++; $display("FAIL init_rom_addr got=%0d exp=1", rom_addr); end
        step(1199);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_early got=%b exp=0", ready); end
        step(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL init_ready got=%b exp=1", ready); end
        n_checks++; if (pellets_left !== 11'd3) begin n_fail++; $display("FAIL init_left got=%0d exp=3", pellets_left); end
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL init_score got=%0d exp=0", score); end
        n_checks++; if (level_clear !== 1'b0) begin n_fail++; $display("FAIL init_clear got=%b exp=0", level_clear); end
    endtask

    task automatic test_pixels;
        logic [9:0] dx [8] = '{10'd22, 10'd6, 10'd5, 10'd9, 10'd10, 10'd630, 10'd662, 10'd22};
        logic [9:0] dy [8] = '{10'd6,  10'd6, 10'd6, 10'd9, 10'd9,  10'd470, 10'd6,   10'd22};
        logic       ex [8] = '{1'b0,   1'b1,  1'b0,  1'b1,  1'b0,   1'b1,    1'b0,    1'b1};
        for (int i = 0; i < 8; i++) begin
            DrawX = dx[i]; DrawY = dy[i];
            #1;
            n_checks++;
            if (pellet_pix !== ex[i]) begin
                n_fail++;
                $display("FAIL pix_%0d (x=%0d y=%0d) got=%b exp=%b", i, dx[i], dy[i], pellet_pix, ex[i]);
            end
        end
    endtask

    task automatic test_eat;
        DrawX = 10'd22; DrawY = 10'd22;
        BallX = 10'd8; BallY = 10'd8; frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL eat_lookup_pulse got=%b exp=0", eat_pulse); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL eat_lookup_ready got=%b exp=0", ready); end
        step(1);
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL eat_pulse got=%b exp=1", eat_pulse); end
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL eat_score_early got=%0d exp=0", score); end
        n_checks++; if (pellet_pix !== 1'b1) begin n_fail++; $display("FAIL eat_pix_update got=%b exp=1", pellet_pix); end
        step(1);
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL eat_pulse_end got=%b exp=0", eat_pulse); end
        n_checks++; if (score !== 16'd10) begin n_fail++; $display("FAIL eat_score got=%0d exp=10", score); end
        n_checks++; if (pellets_left !== 11'd2) begin n_fail++; $display("FAIL eat_left got=%0d exp=2", pellets_left); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL eat_ready got=%b exp=1", ready); end
        n_checks++; if (pellet_pix !== 1'b0) begin n_fail++; $display("FAIL eat_pix_cleared got=%b exp=0", pellet_pix); end
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL reeat_pulse got=%b exp=0", eat_pulse); end
        step(1);
        n_checks++; if (score !== 16'd10) begin n_fail++; $display("FAIL reeat_score got=%0d exp=10", score); end
    endtask

    task automatic test_out_of_range;
        BallX = 10'd640; BallY = 10'd100; frame_tick = 1'b1;
        step(1);
        step(1);  // tick held high through LOOKUP must not be queued
        frame_tick = 1'b0;
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL oor_pulse got=%b exp=0", eat_pulse); end
        step(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready got=%b exp=1", ready); end
        step(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL oor_not_queued got=%b exp=1", ready); end
        n_checks++; if (pellets_left !== 11'd2) begin n_fail++; $display("FAIL oor_left got=%0d exp=2", pellets_left); end
        n_checks++; if (score !== 16'd10) begin n_fail++; $display("FAIL oor_score got=%0d exp=10", score); end
    endtask

    task automatic test_clear;
        logic p;
        eat_one(10'd0, 10'd0, p);
        n_checks++; if (p !== 1'b1) begin n_fail++; $display("FAIL clear_eat0 got=%b exp=1", p); end
        n_checks++; if (level_clear !== 1'b0) begin n_fail++; $display("FAIL clear_early got=%b exp=0", level_clear); end
        eat_one(10'd624, 10'd464, p);
        n_checks++; if (p !== 1'b1) begin n_fail++; $display("FAIL clear_eat1199 got=%b exp=1", p); end
        n_checks++; if (level_clear !== 1'b1) begin n_fail++; $display("FAIL clear_level got=%b exp=1", level_clear); end
        n_checks++; if (score !== 16'd30) begin n_fail++; $display("FAIL clear_score got=%0d exp=30", score); end
    endtask

    task automatic test_restart;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready); end
        n_checks++; if (pellets_left !== 11'd0) begin n_fail++; $display("FAIL rst_left got=%0d exp=0", pellets_left); end
        n_checks++; if (score !== 16'd30) begin n_fail++; $display("FAIL rst_score got=%0d exp=30", score); end
        n_checks++; if (level_clear !== 1'b0) begin n_fail++; $display("FAIL rst_clear got=%b exp=0", level_clear); end
        step(500);
        n_checks++; if (pellets_left !== 11'd2) begin n_fail++; $display("FAIL rst_partial got=%0d exp=2", pellets_left); end
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        n_checks++; if (pellets_left !== 11'd0) begin n_fail++; $display("FAIL rst_again_left got=%0d exp=0", pellets_left); end
        n_checks++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL rst_again_addr got=%0d exp=0", rom_addr); end
        step(1200);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_early got=%b exp=0", ready); end
        step(1);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_end got=%b exp=1", ready); end
        n_checks++; if (pellets_left !== 11'd3) begin n_fail++; $display("FAIL rst_left_end got=%0d exp=3", pellets_left); end
        n_checks++; if (score !== 16'd30) begin n_fail++; $display("FAIL rst_score_end got=%0d exp=30", score); end
    endtask

    task automatic test_reset_priority;
        BallX = 10'd8; BallY = 10'd8; frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        n_checks++; if (eat_pulse !== 1'b1) begin n_fail++; $display("FAIL prio_in_update got=%b exp=1", eat_pulse); end
        Reset_n = 1'b0; restart = 1'b1; frame_tick = 1'b1;
        step(1);
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL prio_score got=%0d exp=0", score); end
        n_checks++; if (eat_pulse !== 1'b0) begin n_fail++; $display("FAIL prio_eat got=%b exp=0", eat_pulse); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready got=%b exp=0", ready); end
        n_checks++; if (pellets_left !== 11'd0) begin n_fail++; $display("FAIL prio_left got=%0d exp=0", pellets_left); end
        Reset_n = 1'b1; restart = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic test_empty_rom;
        rom_mode = 2;
        step(1200);
        n_checks++; if (level_clear !== 1'b0) begin n_fail++; $display("FAIL empty_clear_early got=%b exp=0", level_clear); end
        step(1);
        n_checks++; if (level_clear !== 1'b1) begin n_fail++; $display("FAIL empty_clear got=%b exp=1", level_clear); end
        n_checks++; if (pellets_left !== 11'd0) begin n_fail++; $display("FAIL empty_left got=%0d exp=0", pellets_left); end
    endtask

    task automatic test_saturation;
        logic p;
        int eats = 0;
        int pulses = 0;
        rom_mode = 1;
        for (int lvl = 0; lvl < 6; lvl++) begin
            restart = 1'b1;
            step(1);
            restart = 1'b0;
            step(1201);
            if (lvl == 0) begin
                n_checks++; if (pellets_left !== 11'd1200) begin n_fail++; $display("FAIL sat_full_map got=%0d exp=1200", pellets_left); end
            end
            for (int t = 0; t < 1200 && eats < 6555; t++) begin
                eat_one(10'((t % 40) * 16), 10'((t / 40) * 16), p);
                eats++;
                if (p === 1'b1) pulses++;
                if (eats == 6553) begin
                    n_checks++; if (score !== 16'd65530) begin n_fail++; $display("FAIL sat_65530 got=%0d exp=65530", score); end
                end
                if (eats == 6554) begin
                    n_checks++; if (score !== 16'd65535) begin n_fail++; $display("FAIL sat_first got=%0d exp=65535", score); end
                end
                if (eats == 6555) begin
                    n_checks++; if (p !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got=%b exp=1", p); end
                    n_checks++; if (score !== 16'd65535) begin n_fail++; $display("FAIL sat_hold got=%0d exp=65535", score); end
                end
            end
        end
        n_checks++; if (pulses != 6555) begin n_fail++; $display("FAIL sat_pulse_count got=%0d exp=6555", pulses); end
        n_checks++; if (pellets_left !== 11'd645) begin n_fail++; $display("FAIL sat_left got=%0d exp=645", pellets_left); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_eat();
        test_out_of_range();
        test_clear();
        test_restart();
        test_reset_priority();
        test_empty_rom();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pellet_tracker.md
# pellet_tracker

Downstream consumer of the player sprite's position. Once per frame it converts the player's centre point to a 16×16 tile index, and if that tile still holds a pellet it clears the pellet, adds to the score and decrements the remaining-pellet count. It also feeds the colour mapper a per-pixel "pellet here" bit and tells the game controller when the level is cleared.

## Interface
Parameters:
- TILE_COLS, 40, tiles per row (640 / 16)
- TILE_ROWS, 30, tiles per column (480 / 16)
- PELLET_VALUE, 10, score added per pellet eaten

Ports:
- Clk  in  1  system clock; all state changes on posedge
- Reset_n  in  1  one clock; reset is synchronous and active-low
- frame_tick  in  1  one-Clk pulse per video frame
- restart  in  1  one-Clk pulse; reload the pellet map for a new level and keep the score
- BallX, BallY  in  10  top-left pixel of the 16×16 player sprite
- rom_addr  out  11  pellet-map ROM address = row*TILE_COLS + col
- rom_data  in  1  ROM bit for the address driven on the previous cycle (1 = pellet)
- DrawX, DrawY  in  10  current VGA pixel
- pellet_pix  out  1  combinational; draw a pellet pixel at DrawX/DrawY
- score  out  16  accumulated score, saturating
- pellets_left  out  11  pellets remaining in the map
- eat_pulse  out  1  one-cycle strobe when a pellet is consumed
- level_clear  out  1  high while ready and pellets_left == 0
- ready  out  1  high in IDLE

## Operation
- Storage: TILE_COLS*TILE_ROWS bitmap of registers, indexed by row*TILE_COLS + col.
- States: INIT, IDLE, LOOKUP, UPDATE.
- INIT:
  - Idx counter k sweeps 0..N-1 (N = 1200).
  - rom_addr = k. On the next cycle, bitmap[k-1] <= rom_data and pellets_left increments if rom_data = 1.
  - After writing bit N-1, go to IDLE.
- IDLE: ready = 1. A frame_tick moves to LOOKUP. frame_tick in any other state is ignored and is not queued.
- LOOKUP:
  - cx = BallX + 8 and cy = BallY + 8, both 11 bits with no wrap.
  - col = cx[10:4], row = cy[10:4].
  - Register the index plus a valid flag. valid = 0 when col ≥ TILE_COLS or row ≥ TILE_ROWS.
- UPDATE: if valid and the bitmap bit is 1:
  - clear the bit;
  - score <= min(score + PELLET_VALUE, 65535);
  - pellets_left decrements;
  - eat_pulse = 1 for this cycle.
  - Then return to IDLE.
- restart, from any state:
  - next state INIT with k = 0;
  - whole bitmap cleared and pellets_left = 0;
  - score held;
  - asserting restart during INIT restarts the sweep.
- Reset_n low has priority over restart and frame_tick.
- pellet_pix = 1 only when all of these hold:
  - DrawX[9:4] < TILE_COLS and DrawY[9:4] < TILE_ROWS;
  - the bitmap bit for that tile is 1;
  - DrawX[3:0] is in 6..9 and DrawY[3:0] is in 6..9 (4×4 dot centred in the tile).
- During INIT, pellet_pix reflects the partially loaded map.
- level_clear is combinational from ready and pellets_left. An all-zero ROM gives level_clear = 1 as soon as INIT completes.

## Timing
- Reset values:
  - state INIT, k = 0, rom_addr = 0;
  - bitmap all 0, pellets_left = 0, score = 0;
  - eat_pulse = 0, ready = 0, level_clear = 0, pellet_pix = 0.
- INIT takes N+1 cycles after Reset_n rises (or after restart): rom_addr 0..N-1, then one final write cycle. ready rises on cycle N+1.
- frame_tick to eat_pulse is 2 cycles: IDLE→LOOKUP on the tick edge, LOOKUP→UPDATE, and eat_pulse is asserted in UPDATE. score and pellets_left change on the edge leaving UPDATE. The FSM is back in IDLE 3 cycles after the tick.
- At most one pellet is eaten per frame_tick.
- BallX/BallY are sampled in LOOKUP only. The player updates once per frame, so they are stable.
- pellet_pix has zero latency from DrawX/DrawY.
- A bitmap clear appears on pellet_pix on the cycle after UPDATE.
- Saturation: when score = 65530, the next eat gives 65535, and further eats hold at 65535 while still pulsing eat_pulse.

## Test plan
- Reset, ROM with pellets at indices 0, 41 and 1199 → after 1201 cycles: ready = 1, pellets_left = 3, score = 0, level_clear = 0.
- BallX = 8, BallY = 8 (centre 16,16 → tile 41), frame_tick → eat_pulse on cycle +2, score = 10, pellets_left = 2. A second frame_tick at the same position → no pulse, score stays 10.
- DrawX = 22, DrawY = 6 (tile 1, not a pellet) → pellet_pix 0. DrawX = 6, DrawY = 6 (tile 0) → 1. DrawX = 5, DrawY = 6 → 0.
- BallX = 640, BallY = 100 (col 40, out of range), frame_tick → no eat and no state corruption. frame_tick during LOOKUP → ignored.
- Eat the remaining pellets → level_clear = 1. restart → ready = 0 and pellets_left = 0 during the sweep, score retained, pellets_left = 3 after 1201 cycles.
- Reset_n low during UPDATE with restart also high → next cycle: INIT, score = 0, eat_pulse = 0. Also preload score near 65535 and confirm saturation.
